fetch_unit: RTL and testbench

//   Instruction fetch stage feeding ctrl_unit. Holds PC and instruction register (IR) and runs the

---
 rtl/fetch_unit_pkg.sv | 6 +
 rtl/fetch_unit_pc_counter.sv | 52 +++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage: FSM state codes and opcode field geometry.
package fetch_unit_pkg;
  localparam logic [0:0] FETCH_IDLE = 1'b0;
  localparam logic [0:0] FETCH_READ = 1'b1;
  localparam int         OPC_W      = 5;
endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter for the fetch stage: jump load, post-fetch increment with wrap,
// and a pending-jump register for jumps requested while a read is in flight.
module fetch_unit_pc_counter #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idle_jump_i,  // direct PC load, only while idle
  input  logic              read_jump_i,  // jump requested during a read: deferred
  input  logic              adv_i,        // read completed: move to next PC
  input  logic              abort_i,      // read abandoned: drop any deferred jump
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic [ADDR_W-1:0] pc_o
);
  logic [ADDR_W-1:0] pc_q, pc_d, tgt_q, tgt_d;
  logic              pend_q, pend_d;

  // Next PC: a jump arriving with the ack is the newest target, so it beats the latched one.
  always_comb begin
    pc_d   = pc_q;
    tgt_d  = tgt_q;
    pend_d = pend_q;
    if (idle_jump_i) pc_d = jump_addr_i;
    if (read_jump_i) begin
      pend_d = 1'b1;
      tgt_d  = jump_addr_i;
    end
    if (adv_i) begin
      if (read_jump_i)  pc_d = jump_addr_i;
      else if (pend_q)  pc_d = tgt_q;
      else              pc_d = pc_q + 1'b1;
      pend_d = 1'b0;
    end
    if (abort_i) pend_d = 1'b0;
  end

  // PC, target and pending flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      tgt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      tgt_q  <= tgt_d;
      pend_q <= pend_d;
    end
  end

  assign pc_o = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: IDLE/READ handshake with instruction memory, IR capture,
// opcode export to ctrl_unit. Optional ack-timeout behind FETCH_TIMEOUT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_ack,
  output logic [INSTR_W-1:0] ir,
  output logic [OPC_W-1:0]   opcode,
  output logic [ADDR_W-1:0]  pc,
  output logic               ir_valid,
  output logic               busy,
  output logic               fetch_fault
);
  logic [0:0]         state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q;
  logic               in_read, ack_rd, tmo;

  assign in_read = (state_q == FETCH_READ);
  assign ack_rd  = in_read && imem_ack;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          fault_q;

  // Ack has priority: timeout only fires on the TIMEOUT-th read cycle with no ack.
  assign tmo = in_read && !imem_ack && (cnt_q == CW'(TIMEOUT - 1));

  // Wait counter held at zero while idle so every read starts counting afresh; sticky fault.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      if (!in_read || ack_rd || tmo) cnt_q <= '0;
      else                           cnt_q <= cnt_q + 1'b1;
      if (tmo) fault_q <= 1'b1;
    end
  end
  assign fetch_fault = fault_q;
`else
  logic unused_tmo;
  assign unused_tmo  = ^TIMEOUT;
  assign tmo         = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // FSM and IR next state: a read ends on ack (load data) or timeout (clear IR).
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    if (!in_read) begin
      if (fetch_req) state_d = FETCH_READ;
    end else if (ack_rd) begin
      ir_d    = imem_data;
      state_d = FETCH_IDLE;
    end else if (tmo) begin
      ir_d    = '0;
      state_d = FETCH_IDLE;
    end
  end

  // State, IR and the ir_valid pulse that accompanies each IR update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH_IDLE;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_valid_q <= ack_rd || tmo;
    end
  end

  fetch_unit_pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .idle_jump_i (!in_read && jump_en),
    .read_jump_i (in_read && jump_en),
    .adv_i       (ack_rd),
    .abort_i     (tmo),
    .jump_addr_i (jump_addr),
    .pc_o        (pc)
  );

  assign imem_addr = pc;
  assign imem_rd   = in_read;
  assign busy      = in_read;
  assign ir        = ir_q;
  assign opcode    = ir_q[INSTR_W-1 -: OPC_W];
  assign ir_valid  = ir_valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, fetch latency, delayed ack, wrap, jumps, reset abort, timeout.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n, fetch_req, jump_en, imem_rd, imem_ack, ir_valid, busy, fetch_fault;
  logic [7:0]  jump_addr, imem_addr, pc;
  logic [15:0] imem_data, ir;
  logic [4:0]  opcode;
  int          n_chk = 0;
  int          n_fail = 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .jump_en(jump_en), .jump_addr(jump_addr),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data), .imem_ack(imem_ack),
    .ir(ir), .opcode(opcode), .pc(pc), .ir_valid(ir_valid), .busy(busy), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; fetch_req = 1'b0; jump_en = 1'b0; jump_addr = '0;
    imem_ack = 1'b0; imem_data = '0;
    tick(); tick();
    chk("rst_pc", pc, 0); chk("rst_ir", ir, 0); chk("rst_vld", ir_valid, 0);
    chk("rst_busy", busy, 0); chk("rst_rd", imem_rd, 0); chk("rst_fault", fetch_fault, 0);

    // zero-wait fetch
    rst_n = 1'b1; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("f0_busy", busy, 1); chk("f0_addr", imem_addr, 8'h00); chk("f0_vld_early", ir_valid, 0);
    imem_ack = 1'b1; imem_data = 16'h3A5C;
    tick();
    imem_ack = 1'b0; imem_data = 16'hFFFF;
    chk("f0_ir", ir, 16'h3A5C); chk("f0_opc", opcode, 5'b00111); chk("f0_pc", pc, 8'h01);
    chk("f0_vld", ir_valid, 1); chk("f0_idle", busy, 0);
    tick();
    chk("f0_vld_once", ir_valid, 0); chk("f0_ir_hold", ir, 16'h3A5C);

    // ack after 5 wait cycles: six READ cycles total
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("d5_busy", busy, 1); chk("d5_rd", imem_rd, 1); chk("d5_addr", imem_addr, 8'h01);
      chk("d5_ir_hold", ir, 16'h3A5C); chk("d5_novld", ir_valid, 0);
      if (i == 5) begin imem_ack = 1'b1; imem_data = 16'h1234; end
      tick();
    end
    imem_ack = 1'b0;
    chk("d5_ir", ir, 16'h1234); chk("d5_pc", pc, 8'h02); chk("d5_vld", ir_valid, 1);
    chk("d5_idle", busy, 0);

    // jump_en + fetch_req in IDLE: read at target, then target+1
    jump_en = 1'b1; jump_addr = 8'h40; fetch_req = 1'b1;
    tick();
    jump_en = 1'b0; fetch_req = 1'b0;
    chk("jf_pc", pc, 8'h40); chk("jf_addr", imem_addr, 8'h40); chk("jf_busy", busy, 1);
    imem_ack = 1'b1; imem_data = 16'h0800;
    tick();
    imem_ack = 1'b0;
    chk("jf_pc_next", pc, 8'h41); chk("jf_opc", opcode, 5'b00001);

    // wrap at all-ones
    jump_en = 1'b1; jump_addr = 8'hFF;
    tick();
    jump_en = 1'b0;
    chk("wr_pc_ff", pc, 8'hFF); chk("wr_idle", busy, 0);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0; imem_ack = 1'b1; imem_data = 16'hF00F;
    tick();
    imem_ack = 1'b0;
    chk("wr_pc", pc, 8'h00); chk("wr_ir", ir, 16'hF00F);

    // jumps mid-READ at pc=5, last one wins, address undisturbed
    jump_en = 1'b1; jump_addr = 8'h05;
    tick();
    jump_en = 1'b0; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    jump_en = 1'b1; jump_addr = 8'h30;
    tick();
    jump_addr = 8'h20;
    tick();
    jump_en = 1'b0;
    chk("mj_addr", imem_addr, 8'h05); chk("mj_pc", pc, 8'h05); chk("mj_busy", busy, 1);
    imem_ack = 1'b1; imem_data = 16'h5555;
    tick();
    imem_ack = 1'b0;
    chk("mj_pc_tgt", pc, 8'h20);
    // pending flag must have cleared: next plain fetch increments
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("mj_pend_clr", pc, 8'h21);

    // jump_en in the same cycle as the ack
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0; imem_ack = 1'b1; jump_en = 1'b1; jump_addr = 8'h77;
    tick();
    imem_ack = 1'b0; jump_en = 1'b0;
    chk("aj_pc", pc, 8'h77);

    // reset mid-READ, then a late ack
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("ra_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("ra_idle", busy, 0); chk("ra_pc", pc, 8'h00); chk("ra_ir", ir, 16'h0000);
    rst_n = 1'b1; imem_ack = 1'b1; imem_data = 16'hDEAD;
    tick();
    imem_ack = 1'b0;
    chk("ra_late_busy", busy, 0); chk("ra_late_ir", ir, 16'h0000);
    chk("ra_late_vld", ir_valid, 0); chk("ra_late_pc", pc, 8'h00);

    // load a nonzero IR, then a read with no ack
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0; imem_ack = 1'b1; imem_data = 16'hABCD;
    tick();
    imem_ack = 1'b0;
    chk("to_pre_ir", ir, 16'hABCD);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 14; i++) begin
      chk("to_wait_busy", busy, 1);
      tick();
    end
    chk("to_last_busy", busy, 1); chk("to_nofault", fetch_fault, 0);
    tick();
    chk("to_idle", busy, 0); chk("to_fault", fetch_fault, 1); chk("to_ir", ir, 16'h0000);
    chk("to_vld", ir_valid, 1); chk("to_pc", pc, 8'h01);
    tick();
    chk("to_sticky", fetch_fault, 1);
`else
    for (int i = 0; i < 20; i++) begin
      chk("nt_busy", busy, 1); chk("nt_fault", fetch_fault, 0);
      tick();
    end
    imem_ack = 1'b1; imem_data = 16'h0001;
    tick();
    imem_ack = 1'b0;
    chk("nt_ir", ir, 16'h0001); chk("nt_pc", pc, 8'h02); chk("nt_fault_end", fetch_fault, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
